collision_event_ctrl: RTL and testbench
=======================================

Name: collision_event_ctrl

Overview:
- Frame-level sequencer for the per-pixel collision strobes from the border/object crash detector. Those strobes (charCrashLeft/Right, arrowHitTop, arrowHitBubble, bubbleHitChar) are combinational and fire on arbitrary pixels.
- This block accumulates the strobes over one video frame and commits them at startOfFrame as clean per-frame events: movement blocks, arrow kill, bubble-split request with handshake, and life loss.
- It also owns the lives counter, the post-hit freeze/invulnerability timers and the game-over state. It sits between the collision logic and the char/arrow/bubble move modules.

Parameters:
- START_LIVES, 3, lives loaded at reset/restart.
- LIVES_W, 3, width of livesLeft.
- INVULN_FRAMES, 60, frames of invulnerability after a hit.
- FREEZE_FRAMES, 30, frames movement is frozen after a hit (must be ≤ INVULN_FRAMES).
- CNT_W, 7, width of frame timers.

Ports:
- clk in 1 system clock.
- resetN in 1 async active-low reset.
- startOfFrame in 1 one-cycle pulse per frame.
- restart in 1 level; leaves GAMEOVER.
- charCrashLeft in 1 pixel strobe.
- charCrashRight in 1 pixel strobe.
- arrowHitTop in 1 pixel strobe.
- arrowHitBubble in 1 pixel strobe.
- bubbleHitChar in 1 pixel strobe.
- bubbleSplitAck in 1 bubble logic accepted split.
- charBlockLeft out 1 level for whole frame: char may not move left.
- charBlockRight out 1 level for whole frame: char may not move right.
- arrowKill out 1 one-cycle pulse: retract arrow.
- bubbleSplitReq out 1 held until ack.
- lifeLost out 1 one-cycle pulse.
- freeze out 1 level: movement frozen.
- invulnerable out 1 level.
- livesLeft out LIVES_W current lives.
- gameOver out 1 level.

Behaviour:
- Reset (resetN=0, async): all outputs 0 except livesLeft=START_LIVES. Flags and timers cleared; state RUN. Reset mid-handshake drops bubbleSplitReq immediately.
- Sticky flags fL, fR, fTop, fAB, fHit:
  - Each is set on any cycle its strobe is 1.
  - On the startOfFrame cycle the flags are sampled and cleared.
  - A strobe arriving on that same cycle sets the flag for the next frame and is not included in the current sample.
- Commit at startOfFrame, registered, visible the cycle after startOfFrame:
  - charBlockLeft<=fL and charBlockRight<=fR, both held until the next startOfFrame. Both may be 1 together.
  - If fAB: arrowKill pulses for 1 cycle. If bubbleSplitReq=0, set bubbleSplitReq=1. If a request is already pending, the new split is dropped.
  - Else if fTop: arrowKill pulses for 1 cycle.
  - If fHit, invulnerable=0 and state RUN: life-loss sequence (below).
- Split handshake: bubbleSplitReq stays 1 until a cycle with bubbleSplitAck=1, then goes 0 next cycle. An ack while req=0 is ignored.
- Life-loss sequence:
  - livesLeft decrements (saturates at 0) and lifeLost pulses 1 cycle after startOfFrame.
  - Invulnerability timer loads INVULN_FRAMES and the freeze timer loads FREEZE_FRAMES.
  - If the new livesLeft is 0, go to GAMEOVER; otherwise go to HIT.
- FSM:
  - RUN: normal operation. freeze=0.
  - HIT: freeze=1. Arrow/split commits are still processed; fHit is ignored. Each startOfFrame decrements the freeze timer; at 0, return to RUN.
  - GAMEOVER: gameOver=1, freeze=1, charBlockLeft/Right forced to 0, no pulses, bubbleSplitReq cleared. restart=1 (sampled any cycle) reloads livesLeft=START_LIVES, clears the timers and flags, and returns to RUN next cycle.
- invulnerable = (invulnerability timer ≠ 0). The timer decrements on each startOfFrame and saturates at 0. It also runs during HIT.
- Timer loads take priority over decrements in the same cycle.
- A startOfFrame with all flags 0 commits both blocks to 0 and emits no pulses.

Test Plan:
- Reset, then pulse charCrashLeft for 1 cycle mid-frame, then startOfFrame -> charBlockLeft=1 from cycle after SOF for exactly one frame; charBlockRight=0; next SOF with no strobe -> charBlockLeft=0.
- Pulse arrowHitBubble and arrowHitTop in the same frame, hold bubbleSplitAck=0 for 5 cycles then 1 -> one arrowKill pulse after SOF; bubbleSplitReq high 6 cycles then 0. A second arrowHitBubble frame while req is pending -> arrowKill pulses, no extra request.
- bubbleHitChar in frame 0 with START_LIVES=3 -> after SOF livesLeft=2, lifeLost 1 cycle, freeze=1 for 30 SOFs, invulnerable=1 for 60 SOFs. bubbleHitChar in frame 10 -> livesLeft stays 2.
- Three separated hits, each after invulnerability expires -> livesLeft 3→2→1→0, gameOver=1, freeze=1. restart=1 -> livesLeft=3, gameOver=0 next cycle.
- Strobe charCrashRight exactly on the SOF cycle -> not committed that SOF; committed at the following SOF.
- resetN low while bubbleSplitReq=1 and freeze=1 -> all outputs 0 immediately, livesLeft=3.

Source files
------------

// File: rtl/collision_event_ctrl.sv
// collision_event_ctrl: collects per-pixel collision strobes during a video
// frame and commits them at startOfFrame as clean per-frame events. Also
// owns the lives counter, post-hit freeze/invulnerability timers and the
// game-over state.
module collision_event_ctrl #(
  parameter int START_LIVES   = 3,
  parameter int LIVES_W       = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int FREEZE_FRAMES = 30,
  parameter int CNT_W         = 7
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               restart,
  input  logic               charCrashLeft,
  input  logic               charCrashRight,
  input  logic               arrowHitTop,
  input  logic               arrowHitBubble,
  input  logic               bubbleHitChar,
  input  logic               bubbleSplitAck,
  output logic               charBlockLeft,
  output logic               charBlockRight,
  output logic               arrowKill,
  output logic               bubbleSplitReq,
  output logic               lifeLost,
  output logic               freeze,
  output logic               invulnerable,
  output logic [LIVES_W-1:0] livesLeft,
  output logic               gameOver
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HIT  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   INV_LOAD    = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0]   FRZ_LOAD    = CNT_W'(FREEZE_FRAMES);
  localparam logic [LIVES_W-1:0] LIVES_ZERO  = {LIVES_W{1'b0}};
  localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(START_LIVES);

  state_t             state_q, state_d;
  logic               fl_q, fl_d, fr_q, fr_d, ftop_q, ftop_d;
  logic               fab_q, fab_d, fhit_q, fhit_d;
  logic               cbl_q, cbl_d, cbr_q, cbr_d;
  logic               akill_q, akill_d, req_q, req_d, lost_q, lost_d;
  logic               freeze_q, gover_q, inv_out_q;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]   inv_cnt_q, inv_cnt_d, frz_cnt_q, frz_cnt_d;
  logic [LIVES_W-1:0] lives_dec_s;

  // Saturating decrement of the lives counter.
  assign lives_dec_s = (lives_q != LIVES_ZERO) ? (lives_q - LIVES_ONE) : LIVES_ZERO;

  // Next-state logic: flag accumulation, frame commit, timers and FSM.
  always_comb begin
    // A strobe on the SOF cycle belongs to the next frame's flags.
    if (startOfFrame) begin
      fl_d   = charCrashLeft;
      fr_d   = charCrashRight;
      ftop_d = arrowHitTop;
      fab_d  = arrowHitBubble;
      fhit_d = bubbleHitChar;
    end else begin
      fl_d   = fl_q   | charCrashLeft;
      fr_d   = fr_q   | charCrashRight;
      ftop_d = ftop_q | arrowHitTop;
      fab_d  = fab_q  | arrowHitBubble;
      fhit_d = fhit_q | bubbleHitChar;
    end

    state_d   = state_q;
    cbl_d     = cbl_q;
    cbr_d     = cbr_q;
    akill_d   = 1'b0;
    lost_d    = 1'b0;
    lives_d   = lives_q;
    inv_cnt_d = inv_cnt_q;
    frz_cnt_d = frz_cnt_q;
    // Pending request drops the cycle after an ack; an ack without a request is ignored.
    req_d     = req_q & ~bubbleSplitAck;

    // Invulnerability timer counts frames in every state; loads below override.
    if (startOfFrame && (inv_cnt_q != CNT_ZERO)) begin
      inv_cnt_d = inv_cnt_q - CNT_ONE;
    end else begin
      inv_cnt_d = inv_cnt_q;
    end

    if (state_q == ST_OVER) begin
      cbl_d = 1'b0;
      cbr_d = 1'b0;
      req_d = 1'b0;
      if (restart) begin
        lives_d   = LIVES_START;
        inv_cnt_d = CNT_ZERO;
        frz_cnt_d = CNT_ZERO;
        fl_d      = 1'b0;
        fr_d      = 1'b0;
        ftop_d    = 1'b0;
        fab_d     = 1'b0;
        fhit_d    = 1'b0;
        state_d   = ST_RUN;
      end else begin
        state_d = ST_OVER;
      end
    end else if (startOfFrame) begin
      cbl_d   = fl_q;
      cbr_d   = fr_q;
      akill_d = fab_q | ftop_q;
      // A split while one is already pending is dropped.
      if (fab_q && !req_q) begin
        req_d = 1'b1;
      end else begin
        req_d = req_q & ~bubbleSplitAck;
      end

      if (state_q == ST_HIT) begin
        if (frz_cnt_q <= CNT_ONE) begin
          frz_cnt_d = CNT_ZERO;
          state_d   = ST_RUN;
        end else begin
          frz_cnt_d = frz_cnt_q - CNT_ONE;
        end
      end else begin
        frz_cnt_d = frz_cnt_q;
      end

      // Life loss only when running and not protected by invulnerability.
      if (fhit_q && (inv_cnt_q == CNT_ZERO) && (state_q == ST_RUN)) begin
        lives_d   = lives_dec_s;
        lost_d    = 1'b1;
        inv_cnt_d = INV_LOAD;
        frz_cnt_d = FRZ_LOAD;
        if (lives_dec_s == LIVES_ZERO) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_HIT;
        end
      end else begin
        lost_d = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, flags, timers and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_RUN;
      fl_q      <= 1'b0;
      fr_q      <= 1'b0;
      ftop_q    <= 1'b0;
      fab_q     <= 1'b0;
      fhit_q    <= 1'b0;
      cbl_q     <= 1'b0;
      cbr_q     <= 1'b0;
      akill_q   <= 1'b0;
      req_q     <= 1'b0;
      lost_q    <= 1'b0;
      freeze_q  <= 1'b0;
      gover_q   <= 1'b0;
      inv_out_q <= 1'b0;
      lives_q   <= LIVES_START;
      inv_cnt_q <= CNT_ZERO;
      frz_cnt_q <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      fl_q      <= fl_d;
      fr_q      <= fr_d;
      ftop_q    <= ftop_d;
      fab_q     <= fab_d;
      fhit_q    <= fhit_d;
      cbl_q     <= cbl_d;
      cbr_q     <= cbr_d;
      akill_q   <= akill_d;
      req_q     <= req_d;
      lost_q    <= lost_d;
      freeze_q  <= (state_d != ST_RUN);
      gover_q   <= (state_d == ST_OVER);
      inv_out_q <= (inv_cnt_d != CNT_ZERO);
      lives_q   <= lives_d;
      inv_cnt_q <= inv_cnt_d;
      frz_cnt_q <= frz_cnt_d;
    end
  end

  assign charBlockLeft  = cbl_q;
  assign charBlockRight = cbr_q;
  assign arrowKill      = akill_q;
  assign bubbleSplitReq = req_q;
  assign lifeLost       = lost_q;
  assign freeze         = freeze_q;
  assign invulnerable   = inv_out_q;
  assign livesLeft      = lives_q;
  assign gameOver       = gover_q;

endmodule

// File: tb/tb_collision_event_ctrl.sv
// tb_collision_event_ctrl: directed table-driven vectors for frame commits,
// plus hand-written sequences for the split handshake, hit/timer behaviour,
// game over / restart and asynchronous reset.
module tb_collision_event_ctrl;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, restart;
  logic       charCrashLeft, charCrashRight, arrowHitTop, arrowHitBubble, bubbleHitChar;
  logic       bubbleSplitAck;
  logic       charBlockLeft, charBlockRight, arrowKill, bubbleSplitReq, lifeLost;
  logic       freeze, invulnerable, gameOver;
  logic [2:0] livesLeft;

  int checks = 0;
  int errors = 0;

  // strobe bit order {L, R, Top, AB, Hit}; expected order {cbl, cbr, akill, req, lost}
  localparam logic [4:0] S_L   = 5'b10000;
  localparam logic [4:0] S_R   = 5'b01000;
  localparam logic [4:0] S_TOP = 5'b00100;
  localparam logic [4:0] S_AB  = 5'b00010;
  localparam logic [4:0] S_HIT = 5'b00001;
  localparam logic [4:0] S_NO  = 5'b00000;

  typedef struct {
    logic       sof;
    logic [4:0] stb;
    logic       ack;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[17];

  collision_event_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .restart(restart),
    .charCrashLeft(charCrashLeft), .charCrashRight(charCrashRight),
    .arrowHitTop(arrowHitTop), .arrowHitBubble(arrowHitBubble),
    .bubbleHitChar(bubbleHitChar), .bubbleSplitAck(bubbleSplitAck),
    .charBlockLeft(charBlockLeft), .charBlockRight(charBlockRight),
    .arrowKill(arrowKill), .bubbleSplitReq(bubbleSplitReq), .lifeLost(lifeLost),
    .freeze(freeze), .invulnerable(invulnerable), .livesLeft(livesLeft),
    .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic sof, input logic [4:0] stb, input logic ack);
    startOfFrame   = sof;
    charCrashLeft  = stb[4];
    charCrashRight = stb[3];
    arrowHitTop    = stb[2];
    arrowHitBubble = stb[1];
    bubbleHitChar  = stb[0];
    bubbleSplitAck = ack;
    @(posedge clk);
    #1;
  endtask

  // One short frame: a strobe cycle, two idle cycles, then the SOF cycle.
  task automatic frame(input logic [4:0] stb);
    cyc(1'b0, stb, 1'b0);
    cyc(1'b0, S_NO, 1'b0);
    cyc(1'b0, S_NO, 1'b0);
    cyc(1'b1, S_NO, 1'b0);
  endtask

  function automatic logic [4:0] outs();
    return {charBlockLeft, charBlockRight, arrowKill, bubbleSplitReq, lifeLost};
  endfunction

  initial begin
    vecs[0]  = '{1'b0, S_NO,        1'b0, 5'b00000};
    vecs[1]  = '{1'b0, S_L,         1'b0, 5'b00000};
    vecs[2]  = '{1'b0, S_NO,        1'b0, 5'b00000};
    vecs[3]  = '{1'b1, S_NO,        1'b0, 5'b10000};
    vecs[4]  = '{1'b0, S_NO,        1'b0, 5'b10000};
    vecs[5]  = '{1'b0, S_NO,        1'b0, 5'b10000};
    vecs[6]  = '{1'b1, S_R,         1'b0, 5'b00000};
    vecs[7]  = '{1'b0, S_NO,        1'b0, 5'b00000};
    vecs[8]  = '{1'b1, S_NO,        1'b0, 5'b01000};
    vecs[9]  = '{1'b0, S_NO,        1'b0, 5'b01000};
    vecs[10] = '{1'b1, S_NO,        1'b0, 5'b00000};
    vecs[11] = '{1'b0, S_TOP,       1'b0, 5'b00000};
    vecs[12] = '{1'b1, S_NO,        1'b0, 5'b00100};
    vecs[13] = '{1'b0, S_NO,        1'b0, 5'b00000};
    vecs[14] = '{1'b0, S_L | S_R,   1'b0, 5'b00000};
    vecs[15] = '{1'b1, S_NO,        1'b0, 5'b11000};
    vecs[16] = '{1'b1, S_NO,        1'b0, 5'b00000};

    resetN  = 1'b0;
    restart = 1'b0;
    startOfFrame = 1'b0; charCrashLeft = 1'b0; charCrashRight = 1'b0;
    arrowHitTop = 1'b0; arrowHitBubble = 1'b0; bubbleHitChar = 1'b0;
    bubbleSplitAck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {3'b0, outs()}, 8'h00);
    chk("reset_lives", {5'b0, livesLeft}, 8'd3);
    chk("reset_status", {5'b0, freeze, invulnerable, gameOver}, 8'h00);
    resetN = 1'b1;

    // Frame commit vectors
    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].sof, vecs[i].stb, vecs[i].ack);
      chk($sformatf("vec%0d", i), {3'b0, outs()}, {3'b0, vecs[i].exp});
    end

    // Split handshake: AB and Top in the same frame -> one kill, one request
    cyc(1'b0, S_AB | S_TOP, 1'b0);
    cyc(1'b1, S_NO, 1'b0);
    chk("split_kill", {7'b0, arrowKill}, 8'd1);
    chk("split_req0", {7'b0, bubbleSplitReq}, 8'd1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, S_NO, 1'b0);
      chk($sformatf("split_hold%0d", k), {6'b0, arrowKill, bubbleSplitReq}, 8'b01);
    end
    cyc(1'b0, S_NO, 1'b1);
    chk("split_ack_drop", {7'b0, bubbleSplitReq}, 8'd0);
    cyc(1'b0, S_NO, 1'b1);
    chk("ack_ignored", {7'b0, bubbleSplitReq}, 8'd0);

    // Second split while one is pending: kill pulses, no extra request
    frame(S_AB);
    chk("split2_req", {6'b0, arrowKill, bubbleSplitReq}, 8'b11);
    frame(S_AB);
    chk("split3_kill_pending", {6'b0, arrowKill, bubbleSplitReq}, 8'b11);
    cyc(1'b0, S_NO, 1'b1);
    chk("split3_ack", {7'b0, bubbleSplitReq}, 8'd0);
    cyc(1'b0, S_NO, 1'b0);
    chk("split3_no_extra", {7'b0, bubbleSplitReq}, 8'd0);
    cyc(1'b1, S_NO, 1'b0);
    chk("split3_no_extra_sof", {6'b0, arrowKill, bubbleSplitReq}, 8'b00);

    // First hit: lives 3->2, freeze for 30 frames, invulnerable for 60 frames
    frame(S_HIT);
    chk("hit1_lives", {5'b0, livesLeft}, 8'd2);
    chk("hit1_pulse", {4'b0, lifeLost, freeze, invulnerable, gameOver}, 8'b1110);
    cyc(1'b0, S_NO, 1'b0);
    chk("hit1_pulse_end", {7'b0, lifeLost}, 8'd0);
    for (int k = 1; k <= 60; k++) begin
      frame((k == 10) ? S_HIT : S_NO);
      if (k == 10) begin
        chk("hit_invuln_lives", {5'b0, livesLeft}, 8'd2);
        chk("hit_invuln_nolost", {7'b0, lifeLost}, 8'd0);
      end
      if (k == 29 || k == 30 || k == 59 || k == 60) begin
        chk($sformatf("timers_sof%0d", k), {6'b0, freeze, invulnerable},
            {6'b0, (k < 30) ? 1'b1 : 1'b0, (k < 60) ? 1'b1 : 1'b0});
      end
    end

    // Second hit once invulnerability has expired
    frame(S_HIT);
    chk("hit2_lives", {5'b0, livesLeft}, 8'd1);
    chk("hit2_status", {4'b0, lifeLost, freeze, invulnerable, gameOver}, 8'b1110);
    for (int k = 1; k <= 60; k++) frame(S_NO);

    // Third hit -> game over
    frame(S_HIT);
    chk("hit3_lives", {5'b0, livesLeft}, 8'd0);
    chk("hit3_status", {5'b0, lifeLost, freeze, gameOver}, 8'b111);

    // Game over: blocks forced 0, no pulses, no request
    frame(S_L | S_AB | S_TOP);
    chk("over_quiet", {3'b0, outs()}, 8'h00);
    chk("over_hold", {6'b0, freeze, gameOver}, 8'b11);

    // Restart (not on SOF) -> lives reloaded, RUN next cycle
    restart = 1'b1;
    cyc(1'b0, S_NO, 1'b0);
    restart = 1'b0;
    chk("restart_lives", {5'b0, livesLeft}, 8'd3);
    chk("restart_status", {5'b0, freeze, invulnerable, gameOver}, 8'h00);
    cyc(1'b1, S_NO, 1'b0);
    chk("restart_flags_clear", {3'b0, outs()}, 8'h00);

    // Async reset mid-handshake while frozen
    frame(S_AB | S_HIT);
    chk("pre_reset", {5'b0, bubbleSplitReq, freeze, lifeLost}, 8'b111);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_rst_outs", {3'b0, outs()}, 8'h00);
    chk("async_rst_status", {5'b0, freeze, invulnerable, gameOver}, 8'h00);
    chk("async_rst_lives", {5'b0, livesLeft}, 8'd3);
    #2;
    resetN = 1'b1;
    cyc(1'b1, S_NO, 1'b0);
    chk("post_reset", {3'b0, outs()}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
